// File: rtl/exc_pkg.sv
// Shared definitions for the exception initiator: ExcCode values, CP0 status
// bit positions, FSM state encoding and the default handler entry address.
package exc_pkg;

  // ExcCode values placed in the CP0 cause field
  localparam logic [3:0] EXC_SYSCALL = 4'd8;
  localparam logic [3:0] EXC_BREAK   = 4'd9;
  localparam logic [3:0] EXC_TEQ     = 4'd13;

  // Bit positions of the enables inside the CP0 status register
  localparam int ST_GLOBAL  = 0;
  localparam int ST_SYSCALL = 1;
  localparam int ST_BREAK   = 2;
  localparam int ST_TEQ     = 3;

  // Default handler entry address
  localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'h0040_0004;

  // Sequencer states
  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_REDIRECT
  } exc_state_e;

  // An exception class is enabled only when the global enable is also set
  function automatic logic status_en(input logic [3:0] status, input int idx);
    return status[ST_GLOBAL] & status[idx];
  endfunction

endpackage

// File: rtl/exc_prio.sv
// Mask-and-priority encoder: applies CP0 status enables to the decoded
// instruction class and picks SYSCALL > BREAK > TEQ > ERET.
import exc_pkg::*;

module exc_prio (
  input  logic       inst_valid,
  input  logic       is_syscall,
  input  logic       is_break,
  input  logic       is_teq,
  input  logic       is_eret,
  input  logic       teq_eq,
  input  logic [3:0] status,
  output logic       take,
  output logic       take_eret,
  output logic [3:0] cause
);

  logic sys_hit;
  logic brk_hit;
  logic teq_hit;
  logic eret_hit;

  assign sys_hit  = inst_valid & is_syscall & status_en(status, ST_SYSCALL);
  assign brk_hit  = inst_valid & is_break   & status_en(status, ST_BREAK);
  assign teq_hit  = inst_valid & is_teq & teq_eq & status_en(status, ST_TEQ);
  assign eret_hit = inst_valid & is_eret;

  // Fixed-priority selection among the enabled requests
  always_comb begin
    // NOTE: every output gets a default first, so no path leaves a value held and no latch is inferred.
    take      = 1'b0;
    take_eret = 1'b0;
    cause     = 4'd0;
    if (sys_hit) begin
      take  = 1'b1;
      cause = EXC_SYSCALL;
    end else if (brk_hit) begin
      take  = 1'b1;
      cause = EXC_BREAK;
    end else if (teq_hit) begin
      take  = 1'b1;
      cause = EXC_TEQ;
    end else if (eret_hit) begin
      take      = 1'b1;
      take_eret = 1'b1;
    end
  end

endmodule

// File: rtl/exc_unit.sv
// Exception initiator: detects SYSCALL/BREAK/TEQ/ERET in decode, issues the
// CP0 request or eret strobe, drains the pipeline and redirects fetch.
// Optional feature: define EXC_COUNT_EN to add a saturating exc_count output.
import exc_pkg::*;

module exc_unit #(
  parameter int          DRAIN_CYCLES = 2,
  parameter logic [31:0] EXC_VECTOR   = DEFAULT_EXC_VECTOR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_valid,
  input  logic [31:0] inst_pc,
  input  logic        is_syscall,
  input  logic        is_break,
  input  logic        is_teq,
  input  logic        is_eret,
  input  logic        teq_eq,
  input  logic [31:0] cp0_status,
  input  logic [31:0] cp0_epc,
  input  logic        mtc0_active,
  output logic        cp0_exc_req,
  output logic [3:0]  cp0_cause,
  output logic [31:0] cp0_pc,
  output logic        cp0_teq_exc,
  output logic        cp0_eret,
  output logic        stall,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        busy
`ifdef EXC_COUNT_EN
  ,
  output logic [15:0] exc_count
`endif
);

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  exc_state_e  state;
  exc_state_e  state_next;
  logic [3:0]  drain_cnt;
  logic [3:0]  lat_cause;
  logic [31:0] lat_pc;
  logic        lat_eret;
  logic        lat_teq;
  logic [31:0] target;

  logic        take;
  logic        take_eret;
  logic [3:0]  prio_cause;
  logic        take_idle;
  logic        issue_fire;

  // Only the four enable bits of status matter here
  logic        unused_status;
  assign unused_status = ^cp0_status[31:4];

  exc_prio u_prio (
    .inst_valid (inst_valid),
    .is_syscall (is_syscall),
    .is_break   (is_break),
    .is_teq     (is_teq),
    .is_eret    (is_eret),
    .teq_eq     (teq_eq),
    .status     (cp0_status[3:0]),
    .take       (take),
    .take_eret  (take_eret),
    .cause      (prio_cause)
  );

  // Decode flags only matter while idle; afterwards the pipeline is frozen
  assign take_idle  = (state == S_IDLE) && take;
  // An MTC0 in flight holds the request back so CP0 sees one writer per cycle
  assign issue_fire = (state == S_ISSUE) && !mtc0_active;

  // State register, latched instruction context, drain counter and target
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: every register, including the latched context, is cleared by reset so no partial request survives.
    if (!rst) begin
      state     <= S_IDLE;
      drain_cnt <= 4'd0;
      lat_cause <= 4'd0;
      lat_pc    <= 32'd0;
      lat_eret  <= 1'b0;
      lat_teq   <= 1'b0;
      target    <= 32'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all registers update from the same pre-edge values.
      state <= state_next;
      if (take_idle) begin
        lat_cause <= prio_cause;
        lat_pc    <= inst_pc;
        lat_eret  <= take_eret;
        lat_teq   <= teq_eq & (prio_cause == EXC_TEQ);
      end
      if (issue_fire) begin
        target    <= lat_eret ? cp0_epc : EXC_VECTOR;
        drain_cnt <= DRAIN_LOAD;
      end else if (state == S_DRAIN && drain_cnt != 4'd0) begin
        drain_cnt <= drain_cnt - 4'd1;
      end
    end
  end

  // Next-state logic and per-state output decode
  always_comb begin
    state_next     = state;
    cp0_exc_req    = 1'b0;
    cp0_cause      = 4'd0;
    cp0_pc         = 32'd0;
    cp0_teq_exc    = 1'b0;
    cp0_eret       = 1'b0;
    stall          = 1'b0;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    busy           = 1'b0;
    case (state)
      S_IDLE: begin
        if (take) begin
          stall      = 1'b1;
          state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        stall = 1'b1;
        busy  = 1'b1;
        if (!mtc0_active) begin
          flush = 1'b1;
          if (lat_eret) begin
            cp0_eret = 1'b1;
          end else begin
            cp0_exc_req = 1'b1;
            cp0_cause   = lat_cause;
            cp0_pc      = lat_pc;
            cp0_teq_exc = lat_teq;
          end
          state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        stall = 1'b1;
        busy  = 1'b1;
        flush = 1'b1;
        if (drain_cnt == 4'd0) begin
          state_next = S_REDIRECT;
        end
      end
      S_REDIRECT: begin
        stall          = 1'b1;
        busy           = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = target;
        state_next     = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

`ifdef EXC_COUNT_EN
  // Saturating count of exception requests delivered to CP0; eret is not counted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exc_count <= 16'd0;
    end else if (cp0_exc_req && exc_count != 16'hFFFF) begin
      exc_count <= exc_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_exc_unit.sv
// Directed testbench for exc_unit with default DRAIN_CYCLES=2.
module tb_exc_unit;

  logic        clk;
  logic        rst;
  logic        inst_valid;
  logic [31:0] inst_pc;
  logic        is_syscall;
  logic        is_break;
  logic        is_teq;
  logic        is_eret;
  logic        teq_eq;
  logic [31:0] cp0_status;
  logic [31:0] cp0_epc;
  logic        mtc0_active;
  logic        cp0_exc_req;
  logic [3:0]  cp0_cause;
  logic [31:0] cp0_pc;
  logic        cp0_teq_exc;
  logic        cp0_eret;
  logic        stall;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;
`ifdef EXC_COUNT_EN
  logic [15:0] exc_count;
`endif

  int checks   = 0;
  int failures = 0;

  exc_unit dut (
    .clk            (clk),
    .rst            (rst),
    .inst_valid     (inst_valid),
    .inst_pc        (inst_pc),
    .is_syscall     (is_syscall),
    .is_break       (is_break),
    .is_teq         (is_teq),
    .is_eret        (is_eret),
    .teq_eq         (teq_eq),
    .cp0_status     (cp0_status),
    .cp0_epc        (cp0_epc),
    .mtc0_active    (mtc0_active),
    .cp0_exc_req    (cp0_exc_req),
    .cp0_cause      (cp0_cause),
    .cp0_pc         (cp0_pc),
    .cp0_teq_exc    (cp0_teq_exc),
    .cp0_eret       (cp0_eret),
    .stall          (stall),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .busy           (busy)
`ifdef EXC_COUNT_EN
    ,
    .exc_count      (exc_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled around the falling edge
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic clr_dec();
    inst_valid = 1'b0;
    is_syscall = 1'b0;
    is_break   = 1'b0;
    is_teq     = 1'b0;
    is_eret    = 1'b0;
    teq_eq     = 1'b0;
  endtask

  // Cycle T already driven: check T, then the holds, ISSUE, DRAIN x2, REDIRECT, IDLE
  task automatic run_seq(input string tag, input logic eret, input logic [3:0] cause,
                         input logic [31:0] pc, input logic teq, input logic [31:0] target,
                         input int hold);
    check({tag, ".t_stall"}, {31'd0, stall}, 32'd1);
    check({tag, ".t_busy"}, {31'd0, busy}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      cyc(); clr_dec(); mtc0_active = 1'b1; #1;
      check({tag, ".hold_req"}, {30'd0, cp0_exc_req, cp0_eret}, 32'd0);
      check({tag, ".hold_flush"}, {31'd0, flush}, 32'd0);
      check({tag, ".hold_stall"}, {31'd0, stall}, 32'd1);
    end
    cyc(); clr_dec(); mtc0_active = 1'b0; #1;
    check({tag, ".issue_req"}, {31'd0, cp0_exc_req}, {31'd0, !eret});
    check({tag, ".issue_eret"}, {31'd0, cp0_eret}, {31'd0, eret});
    check({tag, ".issue_cause"}, {28'd0, cp0_cause}, {28'd0, cause});
    check({tag, ".issue_pc"}, cp0_pc, pc);
    check({tag, ".issue_teq"}, {31'd0, cp0_teq_exc}, {31'd0, teq});
    check({tag, ".issue_flush"}, {31'd0, flush}, 32'd1);
    for (int i = 0; i < 2; i++) begin
      cyc(); #1;
      check({tag, ".drain_flush"}, {31'd0, flush}, 32'd1);
      check({tag, ".drain_req"}, {30'd0, cp0_exc_req, cp0_eret}, 32'd0);
      check({tag, ".drain_cause"}, {28'd0, cp0_cause}, 32'd0);
      check({tag, ".drain_redir"}, {31'd0, redirect_valid}, 32'd0);
    end
    cyc(); #1;
    check({tag, ".redir_valid"}, {31'd0, redirect_valid}, 32'd1);
    check({tag, ".redir_pc"}, redirect_pc, target);
    check({tag, ".redir_flush"}, {31'd0, flush}, 32'd0);
    check({tag, ".redir_stall"}, {31'd0, stall}, 32'd1);
    cyc(); #1;
    check({tag, ".idle_busy"}, {31'd0, busy}, 32'd0);
    check({tag, ".idle_stall"}, {31'd0, stall}, 32'd0);
    check({tag, ".idle_redir"}, {31'd0, redirect_valid}, 32'd0);
    check({tag, ".idle_rpc"}, redirect_pc, 32'd0);
  endtask

  initial begin
    rst         = 1'b0;
    clr_dec();
    inst_pc     = 32'd0;
    cp0_status  = 32'd0;
    cp0_epc     = 32'd0;
    mtc0_active = 1'b0;
    cyc(); cyc(); #1;
    check("reset_stall", {31'd0, stall}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_rpc", redirect_pc, 32'd0);
    cyc(); rst = 1'b1;

    // SYSCALL with everything enabled
    cyc(); cp0_status = 32'hF; inst_valid = 1'b1; is_syscall = 1'b1;
    inst_pc = 32'h0040_0010; #1;
    run_seq("syscall", 1'b0, 4'd8, 32'h0040_0010, 1'b0, 32'h0040_0004, 0);

    // Status 5: SYSCALL masked, BREAK taken
    cyc(); cp0_status = 32'h5; inst_valid = 1'b1; is_syscall = 1'b1;
    inst_pc = 32'h0040_0014; #1;
    check("masked_sys_stall", {31'd0, stall}, 32'd0);
    cyc(); clr_dec(); #1;
    check("masked_sys_busy", {31'd0, busy}, 32'd0);
    inst_valid = 1'b1; is_break = 1'b1; inst_pc = 32'h0040_0018; #1;
    run_seq("break", 1'b0, 4'd9, 32'h0040_0018, 1'b0, 32'h0040_0004, 0);

    // Status 9: TEQ with rs != rt ignored, then taken
    cyc(); cp0_status = 32'h9; inst_valid = 1'b1; is_teq = 1'b1; teq_eq = 1'b0;
    inst_pc = 32'h0040_001C; #1;
    check("teq_ne_stall", {31'd0, stall}, 32'd0);
    cyc(); #1;
    check("teq_ne_busy", {31'd0, busy}, 32'd0);
    teq_eq = 1'b1; #1;
    run_seq("teq", 1'b0, 4'd13, 32'h0040_001C, 1'b1, 32'h0040_0004, 0);

    // ERET returns to EPC
    cyc(); cp0_status = 32'h0; cp0_epc = 32'h0040_0020; inst_valid = 1'b1;
    is_eret = 1'b1; inst_pc = 32'h0040_0100; #1;
    run_seq("eret", 1'b1, 4'd0, 32'd0, 1'b0, 32'h0040_0020, 0);

    // All flags together: SYSCALL wins
    cyc(); cp0_status = 32'hF; inst_valid = 1'b1; is_syscall = 1'b1; is_break = 1'b1;
    is_teq = 1'b1; teq_eq = 1'b1; is_eret = 1'b1; inst_pc = 32'h0040_0030; #1;
    run_seq("prio_all", 1'b0, 4'd8, 32'h0040_0030, 1'b0, 32'h0040_0004, 0);

    // BREAK masked by status 1: ERET wins
    cyc(); cp0_status = 32'h1; cp0_epc = 32'h0040_0040; inst_valid = 1'b1;
    is_break = 1'b1; is_eret = 1'b1; inst_pc = 32'h0040_0034; #1;
    run_seq("prio_eret", 1'b1, 4'd0, 32'd0, 1'b0, 32'h0040_0040, 0);

    // MTC0 in ISSUE for two cycles delays the request to T+3
    cyc(); cp0_status = 32'hF; inst_valid = 1'b1; is_syscall = 1'b1;
    inst_pc = 32'h0040_0050; #1;
    run_seq("mtc0", 1'b0, 4'd8, 32'h0040_0050, 1'b0, 32'h0040_0004, 2);

    // Reset in the middle of DRAIN
    cyc(); inst_valid = 1'b1; is_syscall = 1'b1; inst_pc = 32'h0040_0060; #1;
    cyc(); clr_dec(); #1;
    check("rst_pre_req", {31'd0, cp0_exc_req}, 32'd1);
    cyc(); #1;
    check("rst_pre_flush", {31'd0, flush}, 32'd1);
    rst = 1'b0; #1;
    check("rst_mid_stall", {31'd0, stall}, 32'd0);
    check("rst_mid_flush", {31'd0, flush}, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_out", {30'd0, cp0_exc_req, redirect_valid}, 32'd0);
    check("rst_mid_rpc", redirect_pc, 32'd0);
    cyc(); rst = 1'b1; #1;
    check("rst_rel_busy", {31'd0, busy}, 32'd0);
    cyc(); inst_valid = 1'b1; is_syscall = 1'b1; inst_pc = 32'h0040_0070; #1;
    run_seq("post_rst", 1'b0, 4'd8, 32'h0040_0070, 1'b0, 32'h0040_0004, 0);
`ifdef EXC_COUNT_EN
    check("exc_count", {16'd0, exc_count}, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
